// File: rtl/reservation_station_pkg.sv
// Shared widths, entry layout and operand wakeup helper for the reservation station.
package reservation_station_pkg;

    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int OP_W      = 4;
    localparam int CDB_PORTS = 4;
    localparam int ROB_SIZE  = 16;
    localparam int RS_DEPTH  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_LD  = 4'h4,
        OP_ST  = 4'h5,
        OP_BR  = 4'h6
    } opcode_e;

    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  own;
    } operand_t;

    typedef struct packed {
        logic            valid;
        logic [OP_W-1:0] opcode;
        logic [TAG_W-1:0] tag;
        operand_t        a;
        operand_t        b;
    } entry_t;

    // A waiting operand takes the broadcast value; a ready one is left untouched.
    function automatic operand_t wake_operand(operand_t cur, logic hit, logic [DATA_W-1:0] v);
        operand_t res;
        res = cur;
        if (!cur.rdy && hit) begin
            res.rdy = 1'b1;
            res.val = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and issue bundle between InstructionBuffer/CDB/FU and the station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                        disp_valid;
    logic [OP_W-1:0]             disp_opcode;
    logic [TAG_W-1:0]            disp_tag;
    logic                        disp_a_valid;
    logic [DATA_W-1:0]           disp_a_value;
    logic [TAG_W-1:0]            disp_a_owner;
    logic                        disp_b_valid;
    logic [DATA_W-1:0]           disp_b_value;
    logic [TAG_W-1:0]            disp_b_owner;
    logic                        full;

    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_value;

    logic                        issue_valid;
    logic                        issue_ready;
    logic [OP_W-1:0]             issue_opcode;
    logic [DATA_W-1:0]           issue_a;
    logic [DATA_W-1:0]           issue_b;
    logic [TAG_W-1:0]            issue_tag;

    modport master (
        output disp_valid, disp_opcode, disp_tag,
        output disp_a_valid, disp_a_value, disp_a_owner,
        output disp_b_valid, disp_b_value, disp_b_owner,
        output cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  full, issue_valid, issue_opcode, issue_a, issue_b, issue_tag
    );

    modport slave (
        input  disp_valid, disp_opcode, disp_tag,
        input  disp_a_valid, disp_a_value, disp_a_owner,
        input  disp_b_valid, disp_b_value, disp_b_owner,
        input  cdb_valid, cdb_tag, cdb_value, issue_ready,
        output full, issue_valid, issue_opcode, issue_a, issue_b, issue_tag
    );

endinterface

// File: rtl/reservation_station_cdb_snoop.sv
// Compares one operand owner tag against every CDB port; lowest matching port supplies the value.
module reservation_station_cdb_snoop
    import reservation_station_pkg::*;
(
    input  logic [TAG_W-1:0]            tag_i,
    input  logic [CDB_PORTS-1:0]        cdb_valid_i,
    input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_i,
    input  logic [CDB_PORTS*DATA_W-1:0] cdb_value_i,
    output logic                        hit_o,
    output logic [DATA_W-1:0]           value_o
);

    // Scan high to low so the lowest matching port is the last one written.
    always_comb begin
        hit_o   = 1'b0;
        value_o = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid_i[p] && (cdb_tag_i[p*TAG_W +: TAG_W] == tag_i)) begin
                hit_o   = 1'b1;
                value_o = cdb_value_i[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: age-ordered entries, CDB wakeup, oldest-ready issue.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    reservation_station_if.slave rs
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             entry_q [DEPTH];
    entry_t             entry_d [DEPTH];
    entry_t             woke    [DEPTH];
    entry_t             shifted [DEPTH];
    entry_t             disp_entry;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   wr_cnt;
    logic               full_q;
    logic [DEPTH-1:0]   ready_vec;
    logic [DEPTH-1:0]   a_hit;
    logic [DEPTH-1:0]   b_hit;
    logic [DATA_W-1:0]  a_val [DEPTH];
    logic [DATA_W-1:0]  b_val [DEPTH];
    logic [IDX_W-1:0]   sel_idx;
    logic               issue_valid;
    logic               issue_fire;
    logic               accept;
    logic               da_hit;
    logic               db_hit;
    logic [DATA_W-1:0]  da_val;
    logic [DATA_W-1:0]  db_val;

    assign accept     = rs.disp_valid && !full_q;
    assign issue_fire = issue_valid && rs.issue_ready;
    // A new op lands just above the surviving entries after any collapse.
    assign wr_cnt     = count_q - CNT_W'(issue_fire);

    // Per-entry wakeup is computed on the source slot, then the collapse mux moves it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        reservation_station_cdb_snoop u_snoop_a (
            .tag_i       (entry_q[gi].a.own),
            .cdb_valid_i (rs.cdb_valid),
            .cdb_tag_i   (rs.cdb_tag),
            .cdb_value_i (rs.cdb_value),
            .hit_o       (a_hit[gi]),
            .value_o     (a_val[gi])
        );
        reservation_station_cdb_snoop u_snoop_b (
            .tag_i       (entry_q[gi].b.own),
            .cdb_valid_i (rs.cdb_valid),
            .cdb_tag_i   (rs.cdb_tag),
            .cdb_value_i (rs.cdb_value),
            .hit_o       (b_hit[gi]),
            .value_o     (b_val[gi])
        );

        assign woke[gi] = {entry_q[gi].valid, entry_q[gi].opcode, entry_q[gi].tag,
                           wake_operand(entry_q[gi].a, a_hit[gi], a_val[gi]),
                           wake_operand(entry_q[gi].b, b_hit[gi], b_val[gi])};

        assign ready_vec[gi] = entry_q[gi].valid && entry_q[gi].a.rdy && entry_q[gi].b.rdy;

        if (gi < DEPTH - 1) begin : g_shift
            assign shifted[gi] = woke[gi+1];
        end else begin : g_top
            assign shifted[gi] = '0;
        end

        assign entry_d[gi] = (accept && (wr_cnt == CNT_W'(gi))) ? disp_entry :
                             (issue_fire && (IDX_W'(gi) >= sel_idx)) ? shifted[gi] :
                             woke[gi];
    end

    reservation_station_cdb_snoop u_snoop_disp_a (
        .tag_i       (rs.disp_a_owner),
        .cdb_valid_i (rs.cdb_valid),
        .cdb_tag_i   (rs.cdb_tag),
        .cdb_value_i (rs.cdb_value),
        .hit_o       (da_hit),
        .value_o     (da_val)
    );
    reservation_station_cdb_snoop u_snoop_disp_b (
        .tag_i       (rs.disp_b_owner),
        .cdb_valid_i (rs.cdb_valid),
        .cdb_tag_i   (rs.cdb_tag),
        .cdb_value_i (rs.cdb_value),
        .hit_o       (db_hit),
        .value_o     (db_val)
    );

    // Build the incoming entry, taking a same-cycle CDB broadcast as a bypass.
    always_comb begin
        disp_entry        = '0;
        disp_entry.valid  = 1'b1;
        disp_entry.opcode = rs.disp_opcode;
        disp_entry.tag    = rs.disp_tag;
        disp_entry.a.own  = rs.disp_a_owner;
        disp_entry.a.rdy  = rs.disp_a_valid || da_hit;
        disp_entry.a.val  = rs.disp_a_valid ? rs.disp_a_value : da_val;
        disp_entry.b.own  = rs.disp_b_owner;
        disp_entry.b.rdy  = rs.disp_b_valid || db_hit;
        disp_entry.b.val  = rs.disp_b_valid ? rs.disp_b_value : db_val;
    end

    // Oldest-ready select: lowest ready index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Occupancy bookkeeping; accept and issue in the same cycle cancel out.
    always_comb begin
        count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);
    end

    // State update; flush drops everything including a same-cycle dispatch.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign issue_valid     = |ready_vec;
    assign rs.issue_valid  = issue_valid;
    assign rs.issue_opcode = issue_valid ? entry_q[sel_idx].opcode : '0;
    assign rs.issue_tag    = issue_valid ? entry_q[sel_idx].tag    : '0;
    assign rs.issue_a      = issue_valid ? entry_q[sel_idx].a.val  : '0;
    assign rs.issue_b      = issue_valid ? entry_q[sel_idx].b.val  : '0;
    assign rs.full         = full_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios plus randomized traffic against an age-ordered queue model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int DEPTH = RS_DEPTH;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reservation_station_if rs_if ();

    reservation_station #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .rs    (rs_if)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        bit                a_rdy;
        logic [DATA_W-1:0] a_val;
        logic [TAG_W-1:0]  a_own;
        bit                b_rdy;
        logic [DATA_W-1:0] b_val;
        logic [TAG_W-1:0]  b_own;
    } mentry_t;

    mentry_t mq[$];

    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].a_rdy && mq[i].b_rdy) return i;
        return -1;
    endfunction

    task automatic cdb_lookup(input logic [TAG_W-1:0] t, output bit hit, output logic [DATA_W-1:0] v);
        hit = 1'b0;
        v   = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (!hit && rs_if.cdb_valid[p] && rs_if.cdb_tag[p*TAG_W +: TAG_W] == t) begin
                hit = 1'b1;
                v   = rs_if.cdb_value[p*DATA_W +: DATA_W];
            end
        end
    endtask

    // One clock edge: the model follows the same edge using the current inputs.
    task automatic cycle();
        int                sel;
        bit                fire;
        bit                acc;
        bit                h;
        logic [DATA_W-1:0] v;
        mentry_t           ne;
        sel  = model_sel();
        fire = (sel >= 0) && rs_if.issue_ready;
        acc  = rs_if.disp_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].a_rdy) begin
                    cdb_lookup(mq[i].a_own, h, v);
                    if (h) begin mq[i].a_rdy = 1'b1; mq[i].a_val = v; end
                end
                if (!mq[i].b_rdy) begin
                    cdb_lookup(mq[i].b_own, h, v);
                    if (h) begin mq[i].b_rdy = 1'b1; mq[i].b_val = v; end
                end
            end
            if (fire) begin
                $display("issue tag=%0d op=%0h a=%h b=%h", mq[sel].tag, mq[sel].op, mq[sel].a_val, mq[sel].b_val);
                mq.delete(sel);
            end
            if (acc) begin
                ne.op    = rs_if.disp_opcode;
                ne.tag   = rs_if.disp_tag;
                ne.a_own = rs_if.disp_a_owner;
                ne.b_own = rs_if.disp_b_owner;
                cdb_lookup(rs_if.disp_a_owner, h, v);
                ne.a_rdy = rs_if.disp_a_valid || h;
                ne.a_val = rs_if.disp_a_valid ? rs_if.disp_a_value : v;
                cdb_lookup(rs_if.disp_b_owner, h, v);
                ne.b_rdy = rs_if.disp_b_valid || h;
                ne.b_val = rs_if.disp_b_valid ? rs_if.disp_b_value : v;
                mq.push_back(ne);
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        reset              = 1'b0;
        flush              = 1'b0;
        rs_if.disp_valid   = 1'b0;
        rs_if.disp_opcode  = '0;
        rs_if.disp_tag     = '0;
        rs_if.disp_a_valid = 1'b0;
        rs_if.disp_a_value = '0;
        rs_if.disp_a_owner = '0;
        rs_if.disp_b_valid = 1'b0;
        rs_if.disp_b_value = '0;
        rs_if.disp_b_owner = '0;
        rs_if.cdb_valid    = '0;
        rs_if.cdb_tag      = '0;
        rs_if.cdb_value    = '0;
        rs_if.issue_ready  = rdy;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                            input bit av, input logic [DATA_W-1:0] aval, input logic [TAG_W-1:0] aown,
                            input bit bv, input logic [DATA_W-1:0] bval, input logic [TAG_W-1:0] bown);
        rs_if.disp_valid   = 1'b1;
        rs_if.disp_opcode  = op;
        rs_if.disp_tag     = tag;
        rs_if.disp_a_valid = av;
        rs_if.disp_a_value = aval;
        rs_if.disp_a_owner = aown;
        rs_if.disp_b_valid = bv;
        rs_if.disp_b_value = bval;
        rs_if.disp_b_owner = bown;
    endtask

    task automatic set_cdb(input int port, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
        rs_if.cdb_valid[port]                = 1'b1;
        rs_if.cdb_tag[port*TAG_W +: TAG_W]   = tag;
        rs_if.cdb_value[port*DATA_W +: DATA_W] = val;
    endtask

    task automatic clean();
        idle(1'b0);
        flush = 1'b1;
        cycle();
        idle(1'b0);
    endtask

    task automatic test_reset();
        idle(1'b0);
        reset = 1'b1;
        cycle();
        cycle();
        idle(1'b0);
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rs_if.issue_valid); end
        total++; if (rs_if.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", rs_if.full); end
        total++; if (rs_if.issue_tag !== 4'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", rs_if.issue_tag); end
    endtask

    task automatic test_basic();
        clean();
        idle(1'b1);
        set_disp(OP_ADD, 4'd3, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rs_if.issue_valid); end
        total++; if (rs_if.issue_tag !== 4'd3) begin bad++; $display("FAIL basic_tag: got %0d want 3", rs_if.issue_tag); end
        total++; if (rs_if.issue_a !== 16'd5 || rs_if.issue_b !== 16'd7) begin bad++; $display("FAIL basic_ops: got a=%0d b=%0d want a=5 b=7", rs_if.issue_a, rs_if.issue_b); end
        cycle();
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: got %b want 0", rs_if.issue_valid); end
    endtask

    task automatic test_wakeup();
        clean();
        set_disp(OP_SUB, 4'd4, 1'b0, 16'd0, 4'd2, 1'b1, 16'd1, 4'd0);
        cycle();
        idle(1'b0);
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL wake_wait: got %b want 0", rs_if.issue_valid); end
        cycle();
        set_cdb(1, 4'd2, 16'h1234);
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_tag !== 4'd4) begin bad++; $display("FAIL wake_issue: got v=%b tag=%0d want v=1 tag=4", rs_if.issue_valid, rs_if.issue_tag); end
        total++; if (rs_if.issue_a !== 16'h1234) begin bad++; $display("FAIL wake_value: got %h want 1234", rs_if.issue_a); end
        cycle();
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL wake_empty: got %b want 0", rs_if.issue_valid); end
    endtask

    task automatic test_bypass();
        clean();
        set_disp(OP_AND, 4'd5, 1'b1, 16'd2, 4'd0, 1'b0, 16'd0, 4'd6);
        set_cdb(3, 4'd6, 16'd9);
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_b !== 16'd9) begin bad++; $display("FAIL bypass: got v=%b b=%0d want v=1 b=9", rs_if.issue_valid, rs_if.issue_b); end
        cycle();
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL bypass_empty: got %b want 0", rs_if.issue_valid); end
    endtask

    task automatic test_full();
        clean();
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            set_disp(OP_OR, 4'(8 + k), 1'b0, 16'd0, 4'(12 + k), 1'b1, 16'(8 + k), 4'd0);
            cycle();
        end
        idle(1'b0);
        total++; if (rs_if.full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", rs_if.full); end
        set_disp(OP_ADD, 4'd7, 1'b1, 16'd1, 4'd0, 1'b1, 16'd1, 4'd0);
        cycle();
        idle(1'b1);
        total++; if (rs_if.full !== 1'b1 || rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL full_drop: got full=%b v=%b want full=1 v=0", rs_if.full, rs_if.issue_valid); end
        set_cdb(0, 4'd14, 16'hBEEF);
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_tag !== 4'd10 || rs_if.issue_a !== 16'hBEEF) begin bad++; $display("FAIL full_wake2: got tag=%0d a=%h want tag=10 a=beef", rs_if.issue_tag, rs_if.issue_a); end
        cycle();
        total++; if (rs_if.full !== 1'b0 || rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL full_clear: got full=%b v=%b want full=0 v=0", rs_if.full, rs_if.issue_valid); end
        set_cdb(2, 4'd15, 16'h0055);
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_tag !== 4'd11 || rs_if.issue_a !== 16'h0055) begin bad++; $display("FAIL full_shift: got tag=%0d a=%h want tag=11 a=0055", rs_if.issue_tag, rs_if.issue_a); end
        cycle();
        set_cdb(0, 4'd12, 16'h00A0);
        set_cdb(1, 4'd13, 16'h00B0);
        rs_if.issue_ready = 1'b0;
        cycle();
        idle(1'b1);
        total++; if (rs_if.issue_tag !== 4'd8) begin bad++; $display("FAIL full_age0: got tag=%0d want 8", rs_if.issue_tag); end
        cycle();
        total++; if (rs_if.issue_tag !== 4'd9 || rs_if.issue_a !== 16'h00B0) begin bad++; $display("FAIL full_age1: got tag=%0d a=%h want tag=9 a=00b0", rs_if.issue_tag, rs_if.issue_a); end
        cycle();
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL full_dropped_lost: got %b want 0", rs_if.issue_valid); end
    endtask

    task automatic test_hold();
        clean();
        set_disp(OP_LD, 4'd1, 1'b1, 16'd1, 4'd0, 1'b1, 16'd2, 4'd0);
        cycle();
        set_disp(OP_ST, 4'd2, 1'b0, 16'd0, 4'd9, 1'b1, 16'd3, 4'd0);
        cycle();
        set_disp(OP_BR, 4'd3, 1'b1, 16'd3, 4'd0, 1'b1, 16'd4, 4'd0);
        cycle();
        idle(1'b0);
        for (int k = 0; k < 3; k++) begin
            total++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_tag !== 4'd1) begin bad++; $display("FAIL hold_%0d: got v=%b tag=%0d want v=1 tag=1", k, rs_if.issue_valid, rs_if.issue_tag); end
            cycle();
        end
        rs_if.issue_ready = 1'b1;
        cycle();
        total++; if (rs_if.issue_tag !== 4'd3 || rs_if.issue_b !== 16'd4) begin bad++; $display("FAIL hold_next: got tag=%0d b=%0d want tag=3 b=4", rs_if.issue_tag, rs_if.issue_b); end
        cycle();
        total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL hold_rest: got %b want 0", rs_if.issue_valid); end
    endtask

    task automatic test_flush();
        for (int mode = 0; mode < 2; mode++) begin
            clean();
            for (int k = 0; k < 3; k++) begin
                set_disp(OP_ADD, 4'(k), 1'b1, 16'(k), 4'd0, 1'b1, 16'(k), 4'd0);
                cycle();
            end
            idle(1'b1);
            if (mode == 0) flush = 1'b1; else reset = 1'b1;
            set_disp(OP_SUB, 4'd5, 1'b1, 16'd1, 4'd0, 1'b1, 16'd1, 4'd0);
            cycle();
            idle(1'b1);
            total++; if (rs_if.issue_valid !== 1'b0 || rs_if.full !== 1'b0) begin bad++; $display("FAIL flush_%0d: got v=%b full=%b want 0 0", mode, rs_if.issue_valid, rs_if.full); end
            cycle();
            total++; if (rs_if.issue_valid !== 1'b0) begin bad++; $display("FAIL flush_lost_%0d: got %b want 0", mode, rs_if.issue_valid); end
        end
    endtask

    task automatic test_random();
        int sel;
        clean();
        for (int n = 0; n < 600; n++) begin
            idle($urandom_range(0, 99) < 50);
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) < 60)
                set_disp(4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1, 16'($urandom), 4'($urandom),
                         $urandom_range(0, 1) == 1, 16'($urandom), 4'($urandom));
            for (int p = 0; p < CDB_PORTS; p++)
                if ($urandom_range(0, 3) == 0) set_cdb(p, 4'($urandom), 16'($urandom));
            cycle();
            sel = model_sel();
            total++;
            if (rs_if.full !== (mq.size() == DEPTH)) begin
                bad++; $display("FAIL rand_full n=%0d: got %b want %b", n, rs_if.full, mq.size() == DEPTH);
            end
            total++;
            if (sel < 0) begin
                if (rs_if.issue_valid !== 1'b0 || rs_if.issue_tag !== 4'd0 || rs_if.issue_a !== 16'd0) begin
                    bad++; $display("FAIL rand_empty n=%0d: got v=%b tag=%0d a=%h want 0", n, rs_if.issue_valid, rs_if.issue_tag, rs_if.issue_a);
                end
            end else if (rs_if.issue_valid !== 1'b1 || rs_if.issue_tag !== mq[sel].tag || rs_if.issue_opcode !== mq[sel].op ||
                         rs_if.issue_a !== mq[sel].a_val || rs_if.issue_b !== mq[sel].b_val) begin
                bad++; $display("FAIL rand_issue n=%0d: got v=%b tag=%0d op=%0h a=%h b=%h want v=1 tag=%0d op=%0h a=%h b=%h",
                                n, rs_if.issue_valid, rs_if.issue_tag, rs_if.issue_opcode, rs_if.issue_a, rs_if.issue_b,
                                mq[sel].tag, mq[sel].op, mq[sel].a_val, mq[sel].b_val);
            end
        end
    endtask

    initial begin
        idle(1'b0);
        reset = 1'b1;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_hold();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
